operand_pairer: RTL

- Upstream feeder for the 32-bit adder stage.
- Takes a single stream of 32-bit words and groups consecutive words into (data_a, data_b) operand pairs: first word becomes data_a, second becomes data_b.
- Buffers completed pairs in a small FIFO and presents them to the adder with a valid/ready handshake.
- Decouples the word-serial producer from the pair-parallel adder.

---
 rtl/operand_pairer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/operand_pairer.sv
// operand_pairer: groups a serial stream of operand words into (a, b) pairs
// and buffers the completed pairs in a show-ahead FIFO for the adder stage.
//
// Optional build macro: OPERAND_PAIRER_DROP_CNT_EN
//   When defined, adds the drop_count output that counts held operands
//   discarded by flush. When undefined, the port and counter are absent.
//
// state  | meaning
// -------+-----------------------------------------------------------
// WAIT_A | no operand held; next accepted word becomes operand a
// HOLD_A | operand a held in a_reg; next accepted word completes pair

module operand_pairer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [DATA_W-1:0]          out_data_a,
    output logic [DATA_W-1:0]          out_data_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       half_pending,
    output logic [$clog2(DEPTH):0]     fifo_level,
`ifdef OPERAND_PAIRER_DROP_CNT_EN
    output logic [CNT_W-1:0]           drop_count,
`endif
    output logic [CNT_W-1:0]           pair_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [0:0] {
        WAIT_A = 1'b0,
        HOLD_A = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   a_reg;
    logic                half_q;

    logic [DATA_W-1:0]   mem_a [DEPTH];
    logic [DATA_W-1:0]   mem_b [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level;
    logic [CNT_W-1:0]    pair_cnt;

    logic                empty;
    logic                full;
    logic                accept;
    logic                push;
    logic                pop;
    logic                drop;

    // FIFO status, taken only from registered level so out_ready never
    // reaches in_ready combinationally.
    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);

    // Flush blocks input in both states; a full FIFO only blocks the word
    // that would complete a pair, so a new operand a is still taken.
    assign in_ready = (state == WAIT_A) ? !flush : (!full && !flush);

    assign accept = in_valid && in_ready;
    assign push   = accept && (state == HOLD_A);
    assign pop    = !empty && out_ready;
    assign drop   = flush && (state == HOLD_A);

    // Pairing FSM: capture operand a, complete the pair, or abandon on flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= WAIT_A;
            a_reg  <= '0;
            half_q <= 1'b0;
        end else begin
            case (state)
                WAIT_A: begin
                    if (accept) begin
                        a_reg  <= in_data;
                        state  <= HOLD_A;
                        half_q <= 1'b1;
                    end
                end
                HOLD_A: begin
                    if (flush) begin
                        state  <= WAIT_A;
                        half_q <= 1'b0;
                    end else if (accept) begin
                        state  <= WAIT_A;
                        half_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= WAIT_A;
                    half_q <= 1'b0;
                end
            endcase
        end
    end

    // Pair storage; contents are only meaningful between rd_ptr and wr_ptr,
    // so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= a_reg;
            mem_b[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH (power of 2).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Delivered-pair counter, free-running wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_cnt <= '0;
        end else if (pop) begin
            pair_cnt <= pair_cnt + CNT_W'(1);
        end
    end

`ifdef OPERAND_PAIRER_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt;

    // Counts held operands discarded by flush; flush with nothing held is free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    assign drop_count = drop_cnt;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    assign out_valid    = !empty;
    assign out_data_a   = empty ? '0 : mem_a[rd_ptr];
    assign out_data_b   = empty ? '0 : mem_b[rd_ptr];
    assign half_pending = half_q;
    assign fifo_level   = level;
    assign pair_count   = pair_cnt;

endmodule
